// File: rtl/quad_gen_pkg.sv
// quad_pkg: shared types and helpers for the quadrature generator.
//   state_t  - generator FSM state (IDLE at detent, DWELL while a step plays out)
//   phase_t  - {a,b} pin pair
//   DETENT   - rest state of the pulled-up encoder pins
//   cw_next / ccw_next - one gray-code transition in each direction
package quad_pkg;

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t DETENT = 2'b11;

  // CW: 11 -> 01 -> 00 -> 10 -> 11 (A changes first, so A leads)
  function automatic phase_t cw_next(phase_t p);
    case (p)
      2'b11:   return 2'b01;
      2'b01:   return 2'b00;
      2'b00:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // CCW: 11 -> 10 -> 00 -> 01 -> 11 (B leads)
  function automatic phase_t ccw_next(phase_t p);
    case (p)
      2'b11:   return 2'b10;
      2'b10:   return 2'b00;
      2'b00:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/quad_gen_if.sv
// quad_gen_if: request/status bundle of the quadrature generator.
//   cw, ccw  - single-cycle step requests
//   en       - allow new steps to start
//   a, b     - registered quadrature outputs
//   busy     - a step is being played out
//   pending  - signed count of queued steps (positive = CW)
//   ovf      - sticky: a request was lost to saturation
// master drives requests (bench / upstream), slave is the generator.
interface quad_gen_if #(parameter int PEND_W = 8);
  logic              cw;
  logic              ccw;
  logic              en;
  logic              a;
  logic              b;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (output cw, ccw, en, input a, b, busy, pending, ovf);
  modport slave  (input cw, ccw, en, output a, b, busy, pending, ovf);
endinterface

// File: rtl/quad_gen_dwell_timer.sv
// dwell_timer: loadable down-counter that times how long each a/b state is held.
//   clk, reset - clock, async active-high reset (counter clears to 0)
//   load       - reload with DWELL_CYCLES (wins over count)
//   count      - decrement while nonzero
//   expire     - last counted cycle of the dwell (count active and value 1)
module dwell_timer #(
  parameter  int DWELL_CYCLES = 50000,
  localparam int W            = $clog2(DWELL_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (load)                cnt <= W'(DWELL_CYCLES);
    else if (count && cnt != '0)  cnt <= cnt - 1'b1;
  end

  // Loaded value D is seen for the first dwell cycle, so expiring on 1
  // holds the state for exactly D cycles.
  assign expire = count && (cnt == W'(1));

endmodule

// File: rtl/quad_gen.sv
// quad_gen: turns cw/ccw step requests into a rotary-encoder style a/b pair.
//   clk, reset - system clock, async active-high reset
//   bus        - quad_gen_if slave: cw/ccw/en in; a/b/busy/pending/ovf out
// Requests accumulate in a saturating signed counter; each accepted step
// plays out four gray transitions, each held DWELL_CYCLES, ending at detent.
module quad_gen
  import quad_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int PEND_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  quad_gen_if.slave   bus
);

  localparam logic signed [PEND_W+1:0] PMAX = (PEND_W+2)'(2**(PEND_W-1) - 1);
  localparam logic signed [PEND_W+1:0] PMIN = ~PMAX;   // -PMAX-1

  state_t                    state;
  phase_t                    phase;
  logic                      dir_ccw;
  logic [1:0]                tcnt;     // transitions made in this step, minus one
  logic signed [PEND_W-1:0]  pend;
  logic                      ovf_q;

  logic                      start;
  logic                      last;
  logic                      expire;
  logic signed [PEND_W+1:0]  take;
  logic signed [PEND_W+1:0]  sum;
  logic                      sat_hi;
  logic                      sat_lo;

  assign start = (state == IDLE) && bus.en && (pend != '0);
  assign last  = (tcnt == 2'd3);

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (start || (expire && !last)),
    .count  (state == DWELL),
    .expire (expire)
  );

  // Two guard bits keep the unsaturated sum exact for overflow detection.
  always_comb begin
    take = '0;
    if (start) take = pend[PEND_W-1] ? '1 : (PEND_W+2)'(1);
    sum    = {{2{pend[PEND_W-1]}}, pend}
           + {{(PEND_W+1){1'b0}}, bus.cw}
           - {{(PEND_W+1){1'b0}}, bus.ccw}
           - take;
    sat_hi = (sum > PMAX);
    sat_lo = (sum < PMIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= DETENT;
      dir_ccw <= 1'b0;
      tcnt    <= 2'd0;
      pend    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (sat_hi)      pend <= PMAX[PEND_W-1:0];
      else if (sat_lo) pend <= PMIN[PEND_W-1:0];
      else             pend <= sum[PEND_W-1:0];
      if (sat_hi || sat_lo) ovf_q <= 1'b1;

      case (state)
        IDLE: if (start) begin
          state   <= DWELL;
          dir_ccw <= pend[PEND_W-1];
          tcnt    <= 2'd0;
          phase   <= pend[PEND_W-1] ? ccw_next(phase) : cw_next(phase);
        end
        DWELL: if (expire) begin
          // Fourth transition already landed on detent; this dwell ends the step.
          if (last) state <= IDLE;
          else begin
            tcnt  <= tcnt + 2'd1;
            phase <= dir_ccw ? ccw_next(phase) : cw_next(phase);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a       = phase[1];
  assign bus.b       = phase[0];
  assign bus.busy    = (state == DWELL);
  assign bus.pending = pend;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: a reference model predicts, per cycle, pending/busy/ovf
// and the time and value of every a/b transition; a monitor compares.
module tb_quad_gen;
  localparam int D    = 4;
  localparam int PW   = 4;
  localparam int PMAX = 7;
  localparam int PMIN = -8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  quad_gen_if #(.PEND_W(PW)) bus();

  quad_gen #(.DWELL_CYCLES(D), .PEND_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int pend; bit busy; bit ovf; } cyc_exp_t;
  typedef struct { int t; logic [1:0] ab; } edge_exp_t;

  cyc_exp_t  cq[$];
  edge_exp_t tq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  logic [1:0] prev_ab = 2'b11;

  // reference model state
  int m_pend = 0;
  bit m_ovf = 1'b0;
  int m_start = -100;
  int m_end = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic bit m_busy(int t);
    return (t > m_start) && (t < m_end);
  endfunction

  // Drive one cycle of inputs and predict the state after the next edge.
  task automatic step(bit c, bit cc, bit e);
    int n, take, np;
    logic [1:0] seq[4];
    @(negedge clk);
    bus.cw = c; bus.ccw = cc; bus.en = e;
    n = cyc;
    take = 0;
    if (!m_busy(n) && e && m_pend != 0) begin
      take = (m_pend > 0) ? 1 : -1;
      if (take > 0) seq = '{2'b01, 2'b00, 2'b10, 2'b11};
      else          seq = '{2'b10, 2'b00, 2'b01, 2'b11};
      for (int k = 0; k < 4; k++) tq.push_back('{t: n + 1 + k * D, ab: seq[k]});
      m_start = n;
      m_end   = n + 1 + 4 * D;
    end
    np = m_pend + int'(c) - int'(cc) - take;
    if (np > PMAX) begin np = PMAX; m_ovf = 1'b1; end
    else if (np < PMIN) begin np = PMIN; m_ovf = 1'b1; end
    m_pend = np;
    cq.push_back('{pend: m_pend, busy: m_busy(n + 1), ovf: m_ovf});
    chk_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    bus.cw = 1'b0; bus.ccw = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_a", int'(bus.a), 1);
    check("rst_b", int'(bus.b), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pending", int'($signed(bus.pending)), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cq.delete(); tq.delete();
    m_pend = 0; m_ovf = 1'b0; m_start = -100; m_end = -100;
    prev_ab = 2'b11;
  endtask

  task automatic drain(int limit);
    int g = 0;
    while ((m_pend != 0 || m_busy(cyc) || m_busy(cyc + 1)) && g < limit) begin
      step(1'b0, 1'b0, 1'b1);
      g++;
    end
    check("drain_timeout", int'(g >= limit), 0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compares every checked cycle and every a/b transition.
  initial begin
    cyc_exp_t  ce;
    edge_exp_t ee;
    logic [1:0] ab;
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        ab = {bus.a, bus.b};
        if (cq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL cycq_empty: no expectation at cycle %0d", cyc);
        end else begin
          ce = cq.pop_front();
          check("pending", int'($signed(bus.pending)), ce.pend);
          check("busy", int'(bus.busy), int'(ce.busy));
          check("ovf", int'(bus.ovf), int'(ce.ovf));
        end
        if (ab != prev_ab) begin
          if (tq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL edge_unexpected: ab %b at cycle %0d, none expected", ab, cyc);
          end else begin
            ee = tq.pop_front();
            check("edge_time", cyc, ee.t);
            check("edge_ab", int'(ab), int'(ee.ab));
          end
        end
        prev_ab = ab;
      end
    end
  end

  initial begin
    int r;
    bus.cw = 1'b0; bus.ccw = 1'b0; bus.en = 1'b0;
    do_reset();

    // reset mid-step while a/b = 00
    step(1, 0, 1);
    repeat (6) step(0, 0, 1);
    check("pre_reset_ab", int'({bus.a, bus.b}), 0);
    do_reset();

    // single CW step
    step(1, 0, 1);
    repeat (20) step(0, 0, 1);

    // mixed queue: three cw then two ccw
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    step(0, 1, 1); step(0, 1, 1);
    repeat (25) step(0, 0, 1);

    // simultaneous requests while idle
    step(1, 1, 1);
    repeat (5) step(0, 0, 1);

    // saturation with en low, then play out
    repeat (10) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    drain(400);

    // enable dropped after the second transition
    do_reset();
    step(1, 0, 1); step(1, 0, 1);
    repeat (5) step(0, 0, 1);
    repeat (30) step(0, 0, 0);
    drain(200);

    // negative saturation and CCW playout
    do_reset();
    repeat (10) step(0, 1, 0);
    repeat (2) step(0, 0, 0);
    drain(400);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      step((r == 0) || (r == 2), (r == 1) || (r == 2) || (r == 3), $urandom_range(0, 7) != 0);
    end
    drain(600);

    @(negedge clk);
    chk_en = 1'b0;
    check("edge_q_left", tq.size(), 0);
    check("cyc_q_left", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
